// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  // Cycles tx_done may stay high after a start pulse before the frame is deemed complete.
  localparam int UART_START_GUARD = 4;
  localparam int GUARD_W          = $clog2(UART_START_GUARD);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request searching ptr+1, ptr+2, ... modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((int'(ptr) + k) % N_REQ);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART TX core among N_REQ byte-stream requesters.
// Handshake: a byte moves from requester i when req_valid[i] and req_ready[i] are both high on a clock edge.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_done,
  output logic               busy,
  output logic               timeout_evt,
  output logic [CNT_W-1:0]   pkt_cnt,
  output logic [1:0]         state_dbg
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [GUARD_W-1:0] guard_cnt_q, guard_cnt_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               last_q, last_d;
  logic               timeout_evt_q, timeout_evt_d;
  logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic               owner_valid;
  logic [7:0]         owner_byte;
  logic               frame_end;

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    owner_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == IDX_W'(i)) owner_byte = req_data[i*8 +: 8];
    end
  end

  assign owner_valid = req_valid[owner_q];

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    ptr_d         = ptr_q;
    idle_cnt_d    = idle_cnt_q;
    guard_cnt_d   = guard_cnt_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    last_d        = last_q;
    timeout_evt_d = 1'b0;
    pkt_cnt_d     = pkt_cnt_q;
    req_ready     = '0;
    frame_end     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d    = pick_idx;
          idle_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        // Accept only once the core is idle, so a frame left running by a reset is never cut.
        if (owner_valid && tx_done) begin
          req_ready[owner_q] = 1'b1;
          tx_data_d          = owner_byte;
          last_d             = req_last[owner_q];
          tx_start_d         = 1'b1;
          idle_cnt_d         = '0;
          guard_cnt_d        = '0;
          state_d            = WAIT_BUSY;
        end else if (!owner_valid) begin
          if (idle_cnt_q == IDLE_W'(TIMEOUT - 1)) begin
            timeout_evt_d = 1'b1;
            ptr_d         = owner_q;
            idle_cnt_d    = '0;
            state_d       = IDLE;
          end else begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          end
        end else begin
          idle_cnt_d = '0;
        end
      end
      WAIT_BUSY: begin
        if (!tx_done) begin
          state_d = WAIT_DONE;
        end else if (!tx_start_q) begin
          // The pulse cycle itself is not counted toward the guard window.
          if (guard_cnt_q == GUARD_W'(UART_START_GUARD - 1)) frame_end = 1'b1;
          else guard_cnt_d = guard_cnt_q + GUARD_W'(1);
        end
      end
      WAIT_DONE: begin
        if (tx_done) frame_end = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (frame_end) begin
      if (last_q) begin
        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
        ptr_d     = owner_q;
        state_d   = IDLE;
      end else begin
        state_d = GRANT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      ptr_q         <= IDX_W'(N_REQ - 1);
      idle_cnt_q    <= '0;
      guard_cnt_q   <= '0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      last_q        <= 1'b0;
      timeout_evt_q <= 1'b0;
      pkt_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
      idle_cnt_q    <= idle_cnt_d;
      guard_cnt_q   <= guard_cnt_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      last_q        <= last_d;
      timeout_evt_q <= timeout_evt_d;
      pkt_cnt_q     <= pkt_cnt_d;
    end
  end

  always_comb begin
    grant = '0;
    if (state_q != IDLE) grant[owner_q] = 1'b1;
  end

  assign busy        = (state_q != IDLE);
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign timeout_evt = timeout_evt_q;
  assign pkt_cnt     = pkt_cnt_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-fed requesters, a TX core model, and a round-robin packet-order reference.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int TMO   = 8;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     req_last;
  logic [N-1:0]     req_ready;
  logic [N-1:0]     grant;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic             tx_done;
  logic             busy;
  logic             timeout_evt;
  logic [CNT_W-1:0] pkt_cnt;
  logic [1:0]       state_dbg;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .grant       (grant),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_done     (tx_done),
    .busy        (busy),
    .timeout_evt (timeout_evt),
    .pkt_cnt     (pkt_cnt),
    .state_dbg   (state_dbg)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Per-requester byte queues: bit 8 is the last flag.
  logic [8:0]  src_q [N][$];
  logic [15:0] exp_q [$];
  int          start_cyc_q [$];
  int          model_ptr = N - 1;
  int          pkt_model = 0;
  bit          tx_no_busy = 0;
  bit          rand_frames = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic int oh_idx(logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g == (N'(1) << i)) return i;
    return 15;
  endfunction

  function automatic bit src_empty();
    int s = 0;
    for (int i = 0; i < N; i++) s += src_q[i].size();
    return (s == 0);
  endfunction

  task automatic drive_req();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[i*8 +: 8] = src_q[i][0][7:0];
        req_last[i]        = src_q[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  // Requester side: capture acceptance mid-cycle, advance queues after the edge.
  initial begin
    logic [N-1:0] acc;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      acc = req_ready;
      if (!rst) begin
        total++;
        if (((acc & ~grant) != '0) || ($countones(acc) > 1) || ((acc & ~req_valid) != '0)) begin
          bad++;
          $display("FAIL ready_legal: req_ready=%b grant=%b req_valid=%b, required one-hot within grant and valid", acc, grant, req_valid);
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      drive_req();
    end
  end

  // TX core model: frame starts one cycle after the pulse; scoreboards each started byte.
  initial begin
    logic [15:0] got;
    logic [15:0] want;
    int fl;
    tx_done = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (tx_start === 1'b1) begin
        start_cyc_q.push_back(cyc);
        got = {8'(oh_idx(grant)), tx_data};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL tx_byte: unexpected start owner=%0d data=%h, required no start", got[15:8], got[7:0]);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            bad++;
            $display("FAIL tx_byte: owner=%0d data=%h, required owner=%0d data=%h", got[15:8], got[7:0], want[15:8], want[7:0]);
          end
        end
        if (!tx_no_busy) begin
          fl = rand_frames ? int'($urandom_range(2, 10)) : 10;
          @(posedge clk);
          #1;
          tx_done = 1'b0;
          repeat (fl) begin
            @(posedge clk);
            #1;
            total++;
            if (tx_start !== 1'b0) begin
              bad++;
              $display("FAIL start_in_frame: tx_start=%b while tx_done low, required 0", tx_start);
            end
          end
          tx_done = 1'b1;
        end
      end
    end
  end

  // Reference: serve whole packets, next requester with pending data after the last owner.
  task automatic predict();
    logic [8:0] m_q [N][$];
    logic [8:0] b;
    int c;
    for (int i = 0; i < N; i++) m_q[i] = src_q[i];
    while (1) begin
      c = -1;
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (model_ptr + k) % N;
        if (c < 0 && m_q[j].size() > 0) c = j;
      end
      if (c < 0) break;
      do begin
        b = m_q[c].pop_front();
        exp_q.push_back({8'(c), b[7:0]});
      end while (!b[8] && m_q[c].size() > 0);
      model_ptr = c;
      if (b[8]) pkt_model++;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (exp_q.size() == 0 && src_empty() && busy === 1'b0 && tx_done === 1'b1) break;
      n++;
      if (n > 3000) begin
        total++;
        bad++;
        $display("FAIL %s_drain: pending=%0d after 3000 cycles, required 0", name, exp_q.size());
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (grant !== 4'b0)       begin bad++; $display("FAIL rst_grant: got %b, required 0", grant); end
    total++; if (req_ready !== 4'b0)   begin bad++; $display("FAIL rst_ready: got %b, required 0", req_ready); end
    total++; if (tx_data !== 8'h00)    begin bad++; $display("FAIL rst_tx_data: got %h, required 00", tx_data); end
    total++; if (tx_start !== 1'b0)    begin bad++; $display("FAIL rst_tx_start: got %b, required 0", tx_start); end
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL rst_busy: got %b, required 0", busy); end
    total++; if (timeout_evt !== 1'b0) begin bad++; $display("FAIL rst_timeout_evt: got %b, required 0", timeout_evt); end
    total++; if (pkt_cnt !== 2'd0)     begin bad++; $display("FAIL rst_pkt_cnt: got %0d, required 0", pkt_cnt); end
    total++; if (state_dbg !== 2'd0)   begin bad++; $display("FAIL rst_state: got %0d, required 0", state_dbg); end
    rst = 1'b0;
    model_ptr = N - 1;
    pkt_model = 0;
  endtask

  task automatic test_single();
    int n = 0;
    int s0;
    s0 = start_cyc_q.size();
    @(negedge clk);
    src_q[1].push_back({1'b0, 8'h41});
    src_q[1].push_back({1'b1, 8'h42});
    predict();
    @(posedge clk);
    #2;
    @(negedge clk);
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL single_idle_ready: got %b, required 0000", req_ready); end
    @(negedge clk);
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL single_accept: got %b, required 0010", req_ready); end
    @(negedge clk);
    total++; if (tx_start !== 1'b1 || tx_data !== 8'h41) begin bad++; $display("FAIL single_first_start: start=%b data=%h, required 1 41", tx_start, tx_data); end
    while (busy === 1'b1 && n < 200) begin
      total++;
      if (grant !== 4'b0010) begin bad++; $display("FAIL single_grant: got %b, required 0010", grant); end
      @(negedge clk);
      n++;
    end
    wait_drain("single");
    total++; if (start_cyc_q.size() - s0 != 2) begin bad++; $display("FAIL single_starts: got %0d, required 2", start_cyc_q.size() - s0); end
    total++; if (pkt_cnt !== 2'(pkt_model)) begin bad++; $display("FAIL single_pkt_cnt: got %0d, required %0d", pkt_cnt, 2'(pkt_model)); end
  endtask

  task automatic test_contention();
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) src_q[i].push_back({1'b1, 8'($urandom)});
      predict();
      wait_drain("contention");
      total++; if (pkt_cnt !== 2'(pkt_model)) begin bad++; $display("FAIL contention_pkt_cnt: got %0d, required %0d", pkt_cnt, 2'(pkt_model)); end
    end
  endtask

  task automatic test_no_interleave();
    @(negedge clk);
    for (int k = 0; k < 3; k++) src_q[0].push_back({(k == 2), 8'($urandom)});
    src_q[2].push_back({1'b1, 8'($urandom)});
    predict();
    wait_drain("no_interleave");
    total++; if (pkt_cnt !== 2'(pkt_model)) begin bad++; $display("FAIL no_interleave_pkt_cnt: got %0d, required %0d", pkt_cnt, 2'(pkt_model)); end
  endtask

  task automatic test_timeout();
    int n = 0;
    int low_cyc = 0;
    int evts = 0;
    bit seen = 0;
    logic [N-1:0] after = '0;
    logic [7:0] b0;
    @(negedge clk);
    src_q[3].push_back({1'b0, 8'h5a});
    exp_q.push_back({8'd3, 8'h5a});
    while (grant !== 4'b1000 && n < 50) begin @(negedge clk); n++; end
    b0 = 8'($urandom);
    src_q[0].push_back({1'b1, b0});
    exp_q.push_back({8'd0, b0});
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (!seen && state_dbg == 2'd1 && grant == 4'b1000 && !req_valid[3]) low_cyc++;
      if (timeout_evt === 1'b1) begin
        evts++;
        if (!seen) begin
          seen = 1;
          total++; if (grant !== 4'b0000) begin bad++; $display("FAIL timeout_grant_cleared: got %b, required 0000", grant); end
        end
      end
      if (seen && after == '0 && grant != '0) after = grant;
      if (seen && busy === 1'b0 && exp_q.size() == 0 && src_empty()) break;
    end
    model_ptr = 0;
    pkt_model++;
    wait_drain("timeout");
    total++; if (evts != 1)         begin bad++; $display("FAIL timeout_evt_count: got %0d, required 1", evts); end
    total++; if (low_cyc != TMO)    begin bad++; $display("FAIL timeout_idle_cycles: got %0d, required %0d", low_cyc, TMO); end
    total++; if (after !== 4'b0001) begin bad++; $display("FAIL timeout_next_grant: got %b, required 0001", after); end
    total++; if (pkt_cnt !== 2'(pkt_model)) begin bad++; $display("FAIL timeout_pkt_cnt: got %0d, required %0d", pkt_cnt, 2'(pkt_model)); end
  endtask

  task automatic test_guard();
    int s0;
    s0 = start_cyc_q.size();
    tx_no_busy = 1;
    @(negedge clk);
    src_q[1].push_back({1'b0, 8'($urandom)});
    src_q[1].push_back({1'b1, 8'($urandom)});
    predict();
    wait_drain("guard");
    tx_no_busy = 0;
    total++;
    if (start_cyc_q.size() - s0 != 2) begin
      bad++; $display("FAIL guard_starts: got %0d, required 2", start_cyc_q.size() - s0);
    end else if (start_cyc_q[s0+1] - start_cyc_q[s0] != 6) begin
      bad++; $display("FAIL guard_gap: got %0d cycles, required 6", start_cyc_q[s0+1] - start_cyc_q[s0]);
    end
    total++; if (pkt_cnt !== 2'(pkt_model)) begin bad++; $display("FAIL guard_pkt_cnt: got %0d, required %0d", pkt_cnt, 2'(pkt_model)); end
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    @(negedge clk);
    src_q[1].push_back({1'b0, 8'($urandom)});
    src_q[1].push_back({1'b1, 8'($urandom)});
    predict();
    while (tx_done !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({grant, req_ready, tx_data, tx_start, busy, timeout_evt, pkt_cnt, state_dbg} !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs: grant=%b ready=%b data=%h start=%b busy=%b evt=%b cnt=%0d state=%0d, required all 0",
               grant, req_ready, tx_data, tx_start, busy, timeout_evt, pkt_cnt, state_dbg);
    end
    total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL mid_reset_frame_live: tx_done=%b, required 0", tx_done); end
    rst = 1'b0;
    // Counter restarts at zero; only the remaining last byte of requester 1 completes a packet.
    pkt_model = 1;
    model_ptr = 1;
    wait_drain("reset_mid");
    total++; if (pkt_cnt !== 2'(pkt_model)) begin bad++; $display("FAIL mid_reset_pkt_cnt: got %0d, required %0d", pkt_cnt, 2'(pkt_model)); end
  endtask

  task automatic test_random();
    rand_frames = 1;
    for (int r = 0; r < 5; r++) begin
      logic [N-1:0] mask;
      mask = N'($urandom_range(1, (1 << N) - 1));
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (mask[i]) begin
          int np;
          np = $urandom_range(1, 2);
          for (int p = 0; p < np; p++) begin
            int len;
            len = $urandom_range(1, 3);
            for (int k = 0; k < len; k++) src_q[i].push_back({(k == len - 1), 8'($urandom)});
          end
        end
      end
      predict();
      wait_drain("random");
      total++; if (pkt_cnt !== 2'(pkt_model)) begin bad++; $display("FAIL random_pkt_cnt: round %0d got %0d, required %0d", r, pkt_cnt, 2'(pkt_model)); end
    end
    rand_frames = 0;
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_ptr = N - 1;
    pkt_model = 0;
    for (int p = 0; p < 5; p++) src_q[2].push_back({1'b1, 8'($urandom)});
    predict();
    wait_drain("wrap");
    total++; if (pkt_cnt !== 2'd1) begin bad++; $display("FAIL wrap_pkt_cnt: got %0d, required 1", pkt_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_contention();
    test_single();
    test_no_interleave();
    test_timeout();
    test_guard();
    test_reset_mid_frame();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
